// File: rtl/game_engine.sv
// Tic-tac-toe style N-in-a-row engine: one neighbour checked per CHECK cycle.
// Optional one-level undo is built when UNDO_EN is defined.
module game_engine #(
    parameter int SIZE    = 3,
    parameter int WIN_LEN = 3,
    parameter int IDX_W   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic                    move_valid,
    input  logic [IDX_W-1:0]        move_row,
    input  logic [IDX_W-1:0]        move_col,
    output logic                    move_ready,
    input  logic                    undo,
    output logic [2*SIZE*SIZE-1:0]  board,
    output logic                    turn,
    output logic [1:0]              status,
    output logic                    move_done,
    output logic                    move_err
);

    localparam int NC = SIZE * SIZE;
    localparam int CW = $clog2(NC);
    localparam int NW = $clog2(NC + 1);
    localparam logic [IDX_W:0]  SZ   = (IDX_W + 1)'(SIZE);
    localparam logic [3:0]      WL   = 4'(WIN_LEN);
    localparam logic [NW-1:0]   FULL = NW'(NC);
    localparam logic [IDX_W:0]  ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, PLACE, CHECK, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NC-1:0][1:0]      board_q, board_d;
    logic                    turn_q, turn_d;
    logic [1:0]              status_q, status_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]        row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]        pr_q, pr_d, pc_q, pc_d;
    logic [1:0]              dir_q, dir_d;
    logic                    side_q, side_d;
    logic [3:0]              step_q, step_d, run_q, run_d;
    logic                    done_q, done_d, err_q, err_d;

    logic [1:0]              mark;
    logic [IDX_W:0]          dr, dc, nr, nc;
    logic                    inb, hit, acc, legal, undo_acc, side_end;

    function automatic logic [CW-1:0] idx(input logic [IDX_W-1:0] r,
                                          input logic [IDX_W-1:0] c);
        return CW'(r) * CW'(SIZE) + CW'(c);
    endfunction

`ifdef UNDO_EN
    logic [CW-1:0] urec_q, urec_d;
    logic          uval_q, uval_d;
    assign undo_acc = undo && uval_q && !new_game &&
                      (state_q == IDLE || state_q == DONE);
`else
    logic unused_undo;
    assign unused_undo = undo;
    assign undo_acc    = 1'b0;
`endif

    assign mark       = turn_q ? 2'b10 : 2'b01;
    assign move_ready = (state_q == IDLE) && !undo_acc;
    assign acc        = move_valid && move_ready;
    assign legal      = ({1'b0, move_row} < SZ) && ({1'b0, move_col} < SZ) &&
                        (board_q[idx(move_row, move_col)] == 2'b00);

    // Step vector for the current direction; the negative side mirrors it.
    always_comb begin
        dr = '0;
        dc = '0;
        unique case (dir_q)
            2'd0:    dc = ONE;
            2'd1:    dr = ONE;
            2'd2:    begin dr = ONE; dc = ONE; end
            default: begin dr = ONE; dc = '1;  end
        endcase
        if (side_q) begin
            dr = -dr;
            dc = -dc;
        end
    end

    assign nr  = {1'b0, pr_q} + dr;
    assign nc  = {1'b0, pc_q} + dc;
    assign inb = !nr[IDX_W] && (nr < SZ) && !nc[IDX_W] && (nc < SZ);
    assign hit = inb &&
                 (board_q[idx(nr[IDX_W-1:0], nc[IDX_W-1:0])] == mark);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        pr_d     = pr_q;
        pc_d     = pc_q;
        dir_d    = dir_q;
        side_d   = side_q;
        step_d   = step_q;
        run_d    = run_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        side_end = 1'b0;
`ifdef UNDO_EN
        urec_d   = urec_q;
        uval_d   = uval_q;
`endif
        if (new_game) begin
            state_d  = IDLE;
            board_d  = '0;
            turn_d   = 1'b0;
            status_d = 2'b00;
            cnt_d    = '0;
            run_d    = 4'd1;
`ifdef UNDO_EN
            uval_d   = 1'b0;
        end else if (undo_acc) begin
            board_d[urec_q] = 2'b00;
            turn_d   = ~turn_q;
            cnt_d    = cnt_q - 1'b1;
            status_d = 2'b00;
            uval_d   = 1'b0;
            state_d  = IDLE;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (acc) begin
                    if (legal) begin
                        row_d   = move_row;
                        col_d   = move_col;
                        state_d = PLACE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                PLACE: begin
                    board_d[idx(row_q, col_q)] = mark;
                    cnt_d   = cnt_q + 1'b1;
                    dir_d   = 2'd0;
                    side_d  = 1'b0;
                    step_d  = 4'd0;
                    run_d   = 4'd1;
                    pr_d    = row_q;
                    pc_d    = col_q;
                    state_d = CHECK;
`ifdef UNDO_EN
                    urec_d  = idx(row_q, col_q);
                    uval_d  = 1'b1;
`endif
                end
                CHECK: begin
                    if (hit) begin
                        if (run_q + 4'd1 >= WL) begin
                            status_d = mark;
                            state_d  = DONE;
                            done_d   = 1'b1;
                        end else begin
                            run_d    = run_q + 4'd1;
                            step_d   = step_q + 4'd1;
                            pr_d     = nr[IDX_W-1:0];
                            pc_d     = nc[IDX_W-1:0];
                            side_end = (step_q + 4'd1 == WL - 4'd1);
                        end
                    end else begin
                        side_end = 1'b1;
                    end
                    // Restart from the placed cell for the next side/direction.
                    if (side_end) begin
                        step_d = 4'd0;
                        pr_d   = row_q;
                        pc_d   = col_q;
                        if (!side_q) begin
                            side_d = 1'b1;
                        end else begin
                            side_d = 1'b0;
                            run_d  = 4'd1;
                            dir_d  = dir_q + 2'd1;
                            if (dir_q == 2'd3) begin
                                done_d = 1'b1;
                                if (cnt_q == FULL) begin
                                    status_d = 2'b11;
                                    state_d  = DONE;
                                end else begin
                                    turn_d  = ~turn_q;
                                    state_d = IDLE;
                                end
                            end
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            board_q  <= '0;
            turn_q   <= 1'b0;
            status_q <= 2'b00;
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pr_q     <= '0;
            pc_q     <= '0;
            dir_q    <= 2'd0;
            side_q   <= 1'b0;
            step_q   <= 4'd0;
            run_q    <= 4'd1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef UNDO_EN
            urec_q   <= '0;
            uval_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pr_q     <= pr_d;
            pc_q     <= pc_d;
            dir_q    <= dir_d;
            side_q   <= side_d;
            step_q   <= step_d;
            run_q    <= run_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef UNDO_EN
            urec_q   <= urec_d;
            uval_q   <= uval_d;
`endif
        end
    end

    assign board     = board_q;
    assign turn      = turn_q;
    assign status    = status_q;
    assign move_done = done_q;
    assign move_err  = err_q;

endmodule

// File: tb/tb_game_engine.sv
// Directed bench for game_engine (SIZE=3, WIN_LEN=3); covers UNDO_EN when defined.
module tb_game_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic        undo = 1'b0;
    logic [2:0]  move_row = '0;
    logic [2:0]  move_col = '0;
    logic        move_ready, turn, move_done, move_err;
    logic [17:0] board;
    logic [1:0]  status;

    int n_assert = 0;
    int n_fail   = 0;

    game_engine #(.SIZE(3), .WIN_LEN(3), .IDX_W(3)) dut (
        .clock(clock), .reset(reset), .new_game(new_game),
        .move_valid(move_valid), .move_row(move_row), .move_col(move_col),
        .move_ready(move_ready), .undo(undo), .board(board), .turn(turn),
        .status(status), .move_done(move_done), .move_err(move_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one move and wait (bounded) for its done/err pulse.
    task automatic mv(input string tag, input int r, input int c,
                      input logic exp_err);
        int lat;
        move_valid = 1'b1;
        move_row   = 3'(r);
        move_col   = 3'(c);
        tick();
        move_valid = 1'b0;
        lat = 1;
        while (!move_done && !move_err && lat < 40) begin
            tick();
            lat++;
        end
        chk(tag, 32'({move_done, move_err}), exp_err ? 32'd1 : 32'd2);
        if (!exp_err)
            chk({tag, "_lat"}, 32'(lat <= 18), 32'd1);
    endtask

    task automatic restart();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready",  32'(move_ready), 32'd1);
        chk("rst_board",  32'(board),      32'd0);
        chk("rst_turn",   32'(turn),       32'd0);
        chk("rst_status", 32'(status),     32'd0);
        chk("rst_pulses", 32'({move_done, move_err}), 32'd0);

        // X wins on the top row
        mv("w1", 0, 0, 1'b0);
        chk("w1_turn", 32'(turn), 32'd1);
        mv("w2", 1, 0, 1'b0);
        chk("w2_turn", 32'(turn), 32'd0);
        mv("w3", 0, 1, 1'b0);
        mv("w4", 1, 1, 1'b0);
        mv("w5", 0, 2, 1'b0);
        chk("win_status", 32'(status),     32'd1);
        chk("win_ready",  32'(move_ready), 32'd0);
        chk("win_row0",   32'(board[5:0]), 32'h15);
        chk("win_board",  32'(board),      32'h00295);
        chk("win_turn",   32'(turn),       32'd0);

        // moves are not accepted in DONE
        move_valid = 1'b1;
        move_row   = 3'd2;
        move_col   = 3'd2;
        for (int i = 0; i < 3; i++) tick();
        move_valid = 1'b0;
        chk("done_board",  32'(board), 32'h00295);
        chk("done_pulses", 32'({move_done, move_err}), 32'd0);

        restart();
        chk("ng_board",  32'(board),      32'd0);
        chk("ng_status", 32'(status),     32'd0);
        chk("ng_turn",   32'(turn),       32'd0);
        chk("ng_ready",  32'(move_ready), 32'd1);

        // occupied cell, then out-of-range row
        mv("occ1", 1, 1, 1'b0);
        mv("occ2", 1, 1, 1'b1);
        chk("occ_turn",  32'(turn),  32'd1);
        chk("occ_board", 32'(board), 32'h00100);
        tick();
        chk("err_pulse", 32'(move_err), 32'd0);
        mv("oob", 3, 0, 1'b1);
        chk("oob_board", 32'(board),      32'h00100);
        chk("oob_turn",  32'(turn),       32'd1);
        chk("oob_ready", 32'(move_ready), 32'd1);

        // full board draw
        restart();
        mv("d1", 0, 0, 1'b0);
        mv("d2", 0, 1, 1'b0);
        mv("d3", 0, 2, 1'b0);
        mv("d4", 1, 1, 1'b0);
        mv("d5", 1, 0, 1'b0);
        mv("d6", 1, 2, 1'b0);
        mv("d7", 2, 1, 1'b0);
        mv("d8", 2, 0, 1'b0);
        chk("d8_status", 32'(status), 32'd0);
        mv("d9", 2, 2, 1'b0);
        chk("draw_status", 32'(status),     32'd3);
        chk("draw_board",  32'(board),      32'h16A59);
        chk("draw_ready",  32'(move_ready), 32'd0);

        // O wins on the anti-diagonal
        restart();
        mv("o1", 0, 0, 1'b0);
        mv("o2", 1, 1, 1'b0);
        mv("o3", 0, 1, 1'b0);
        mv("o4", 0, 2, 1'b0);
        mv("o5", 2, 2, 1'b0);
        mv("o6", 2, 0, 1'b0);
        chk("owin_status", 32'(status), 32'd2);
        chk("owin_board",  32'(board),  32'h12225);
        chk("owin_turn",   32'(turn),   32'd1);

        // reset during CHECK of a winning move
        restart();
        mv("r1", 0, 0, 1'b0);
        mv("r2", 1, 0, 1'b0);
        mv("r3", 0, 1, 1'b0);
        mv("r4", 1, 1, 1'b0);
        move_valid = 1'b1;
        move_row   = 3'd0;
        move_col   = 3'd2;
        tick();
        move_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_board",  32'(board),      32'd0);
        chk("mid_status", 32'(status),     32'd0);
        chk("mid_ready",  32'(move_ready), 32'd1);
        chk("mid_done",   32'(move_done),  32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_quiet", 32'({move_done, status}), 32'd0);
        end

        // undo
        mv("u1", 0, 0, 1'b0);
        undo = 1'b1;
`ifdef UNDO_EN
        chk("undo_ready", 32'(move_ready), 32'd0);
        tick();
        undo = 1'b0;
        chk("undo_board", 32'(board), 32'd0);
        chk("undo_turn",  32'(turn),  32'd0);
        undo = 1'b1;
        tick();
        undo = 1'b0;
        chk("undo2_turn",  32'(turn),       32'd0);
        chk("undo2_board", 32'(board),      32'd0);
        chk("undo2_ready", 32'(move_ready), 32'd1);
`else
        chk("undo_ready", 32'(move_ready), 32'd1);
        tick();
        undo = 1'b0;
        chk("undo_board", 32'(board), 32'h00001);
        chk("undo_turn",  32'(turn),  32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
